counter: RTL and testbench

- Synchronous 14-bit up/down counter spanning 0..9999, with a combinational binary-to-BCD converter on its output.
- The converter drives four BCD digits for a 4-digit 7-segment display path.
- Sits between the board clock/control inputs and the display decoder. The binary value is exported alongside the BCD digits.

---
 rtl/counter_pkg.sv | 8 +
 rtl/counter_bin_to_bcd.sv | 21 ++
 rtl/counter.sv | 28 ++
 tb/tb_counter.sv | 98 +++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared sizes and BCD digit types for the up/down counter and its converter.
package counter_pkg;
  localparam int WIDTH = 14;
  localparam int DIGITS = 4;
  localparam int MAX_COUNT = 9999;
  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [DIGITS-1:0] bcd_t;
endpackage

// File: rtl/counter_bin_to_bcd.sv
// bin_to_bcd: combinational shift-add-3 (double dabble) binary to BCD converter.
module bin_to_bcd #(
  parameter int WIDTH = 14,
  parameter int DIGITS = 4
) (
  input  logic [WIDTH-1:0] binin,
  output logic [3:0]       bcdout [DIGITS-1:0]
);
  logic [4*DIGITS-1:0] bcd;
  always_comb begin
    bcd = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++)
        bcd[4*d+:4] = bcd[4*d+:4] >= 4'd5 ? bcd[4*d+:4] + 4'd3 : bcd[4*d+:4];
      bcd = {bcd[4*DIGITS-2:0], binin[i]};
    end
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign bcdout[g] = bcd[4*g+:4];
  end
endmodule

// File: rtl/counter.sv
// counter: 0..MAX_COUNT wrapping up/down counter with BCD digit output.
// Defining COUNTER_ENABLE_EN adds an enable input that gates counting.
module counter
  import counter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             decrement,
`ifdef COUNTER_ENABLE_EN
  input  logic             enable,
`endif
  output logic [WIDTH-1:0] binout,
  output bcd_digit_t       bcdout [DIGITS-1:0]
);
  localparam logic [WIDTH-1:0] MAX_BIN = WIDTH'(MAX_COUNT);
  logic step;
`ifdef COUNTER_ENABLE_EN
  assign step = enable;
`else
  assign step = 1'b1;
`endif
  always_ff @(posedge clock)
    if (reset) binout <= '0;
    else if (step)
      binout <= decrement ? (binout == '0 ? MAX_BIN : binout - 1'b1)
                          : (binout == MAX_BIN ? '0 : binout + 1'b1);
  bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd (.binin(binout), .bcdout(bcdout));
endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized and directed checks of counter against an arithmetic reference.
module tb_counter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        decrement = 1'b0;
  logic        enable = 1'b1;
  logic [13:0] binout;
  logic [3:0]  bcdout [3:0];
  int m = 0;
  bit valid = 0;
  int total = 0;
  int passed = 0;

  counter dut (
    .clock(clock),
    .reset(reset),
    .decrement(decrement),
`ifdef COUNTER_ENABLE_EN
    .enable(enable),
`endif
    .binout(binout),
    .bcdout(bcdout)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] digits_of(int v);
    return 16'((v / 1000) % 10) << 12 | 16'((v / 100) % 10) << 8 | 16'((v / 10) % 10) << 4 | 16'(v % 10);
  endfunction

  function automatic logic [15:0] got_digits();
    return {bcdout[3], bcdout[2], bcdout[1], bcdout[0]};
  endfunction

  task automatic check(string name, int got, int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic tick(bit r, bit d, bit e);
    reset = r;
    decrement = d;
    enable = e;
    @(posedge clock);
`ifndef COUNTER_ENABLE_EN
    e = 1'b1;
`endif
    if (r) m = 0;
    else if (e) m = (m + (d ? 9999 : 1)) % 10000;
    valid = 1;
    #1;
  endtask

  always @(negedge clock)
    if (valid) begin
      check("binout", int'(binout), m);
      check("bcdout", int'(got_digits()), int'(digits_of(m)));
    end

  initial begin
    tick(1, 0, 1);
    check("reset_bin", int'(binout), 0);
    check("reset_bcd", int'(got_digits()), 'h0000);
    tick(0, 0, 1);
    check("inc_bin", int'(binout), 1);
    check("inc_bcd", int'(got_digits()), 'h0001);
    repeat (1023) tick(0, 0, 1);
    check("long_bin", int'(binout), 1024);
    check("long_bcd", int'(got_digits()), 'h1024);
    repeat (9999 - 1024) tick(0, 0, 1);
    check("max_bcd", int'(got_digits()), 'h9999);
    tick(0, 0, 1);
    check("upwrap_bin", int'(binout), 0);
    tick(0, 1, 1);
    check("downwrap_bin", int'(binout), 9999);
    tick(0, 1, 1);
    check("down_bcd", int'(got_digits()), 'h9998);
    tick(1, 0, 1);
    repeat (537) tick(0, 0, 1);
    check("mid_bin", int'(binout), 537);
    tick(1, 1, 1);
    check("midreset_bin", int'(binout), 0);
    repeat (9999) tick(0, 0, 1);
    check("sweep_end", int'(binout), 9999);
`ifdef COUNTER_ENABLE_EN
    tick(0, 1, 1);
    repeat (5) tick(0, $urandom_range(0, 1), 0);
    check("hold_bin", int'(binout), 9998);
    tick(1, 0, 0);
    check("reset_noen", int'(binout), 0);
`endif
    repeat (3000) tick($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0);
    valid = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
